if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  Instruction-fetch stage and IF/ID pipeline register; feeds pc_o/inst_o/inst_valid_o to the decode stage.
//  Issues word fetches to instruction memory over a req/gnt + rvalid interface and buffers responses in a FIFO.
//  Squashes wrong-path instructions on a redirect from the branch unit.
// PARAMETERS
//  RESET_PC    32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  2              response buffer entries (power of 2, >=2); also the credit limit
// PORTS
//  clk              in   1   clock, all state on rising edge
//  rst              in   1   asynchronous, active-high reset
//  stall_i          in   1   decode cannot accept; hold IF/ID outputs
//  branch_flag_i    in   1   redirect fetch this edge
//  branch_target_i  in   32  redirect address
//  imem_req_o       out  1   fetch request valid
//  imem_addr_o      out  32  fetch address (word aligned)
//  imem_gnt_i       in   1   request accepted this cycle
//  imem_rvalid_i    in   1   response data valid; responses in request order, >=1 cycle after gnt
//  imem_rdata_i     in   32  instruction word
//  pc_o             out  32  pc of inst_o
//  inst_o           out  32  instruction to decode
//  inst_valid_o     out  1   inst_o is a real instruction
//  fetch_exc_o      out  1   misaligned-target exception (see CONFIGURATION)
// BEHAVIOUR
//  Reset (async): fetch_pc=RESET_PC, pc_o=RESET_PC, inst_o=32'h0000_0013 (NOP), inst_valid_o=0,
//   fetch_exc_o=0, FIFO empty, outstanding=0, kill=0. No rvalid may arrive for pre-reset requests.
//  Request: imem_req_o=1 when outstanding+fifo_count<FIFO_DEPTH and no redirect this cycle and !halted.
//   imem_addr_o=fetch_pc (combinational). req&gnt: fetch_pc+=4 (wraps mod 2^32), outstanding+1.
//   req stays high, addr stable, until gnt or redirect.
//  Response: rvalid with kill>0: drop word, kill-1, outstanding-1.
//   Else outstanding-1; word plus its pc (resp_pc, +=4 per accepted response) goes to FIFO or output.
//  Output (IF/ID register), priority order per edge:
//   1) branch_flag_i: inst_valid_o<=0, inst_o<=NOP, pc_o holds; FIFO flushed;
//      kill<=outstanding after this cycle's response/grant accounting;
//      fetch_pc<=target, resp_pc<=target; no request this cycle. Overrides stall_i.
//   2) stall_i: pc_o/inst_o/inst_valid_o hold; responses enter FIFO.
//   3) FIFO non-empty: pop head into outputs, inst_valid_o<=1; same-cycle response pushes.
//   4) FIFO empty and surviving response: bypass into outputs, inst_valid_o<=1.
//   5) nothing: inst_valid_o<=0, inst_o<=NOP, pc_o holds.
//  Latency: gnt cycle N, rvalid N+1, no stall -> inst_valid_o=1 in N+2. Back-to-back: 1 instr/cycle.
//  Full: credit rule guarantees no response arrives with FIFO full; an overflow is a bench assertion failure.
//  Simultaneous push+pop at full: allowed, count unchanged.
//  Counters sized clog2(FIFO_DEPTH)+1; outstanding never exceeds FIFO_DEPTH.
// CONFIGURATION
//  FETCH_MISALIGN_CHK_EN defined: redirect with branch_target_i[1:0]!=0 sets fetch_exc_o=1 (sticky)
//   and pc_o<=target, inst_valid_o<=0. Requests halt until the next aligned redirect, which clears
//   fetch_exc_o.
//  Not defined: fetch_exc_o tied 0; target[1:0] forced to 2'b00.
// TESTING
//  Reset release, gnt=1, 1-cycle rvalid, rdata=0x00500093 -> pc_o=0x0, inst_valid_o=1 two cycles after req.
//  Streaming, no stall -> pc_o 0x0,0x4,0x8,0xC on consecutive cycles; req never exceeds 2 outstanding.
//  stall_i held 3 cycles mid-stream -> outputs frozen; FIFO reaches 2; req drops; on release pc continues
//   +4 with no gap or duplicate.
//  Redirect to 0x100 with 2 outstanding -> both late responses dropped; next valid pc_o=0x100;
//   no wrong-path inst_valid_o.
//  Redirect and stall_i in same cycle -> inst_valid_o=0 next cycle; fetch resumes at target.
//  With FETCH_MISALIGN_CHK_EN, target 0x102 -> fetch_exc_o=1, imem_req_o=0;
//   redirect to 0x200 -> fetch_exc_o=0, fetch resumes.
//  Async rst pulse mid-stream -> all outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch -- instruction-fetch stage with IF/ID pipeline register.
//
// Sends word fetches to instruction memory over a req/gnt request channel
// and an in-order rvalid response channel. Responses go into a small FIFO,
// or straight into the IF/ID register when the FIFO is empty. A redirect from
// the branch unit flushes the FIFO. It also arms a kill counter so that
// wrong-path responses still in flight are dropped when they return.
//
// Optional feature (macro FETCH_MISALIGN_CHK_EN):
//   defined     - a redirect to a target with [1:0]!=0 raises fetch_exc_o
//                 (sticky). It also loads pc_o with the target and halts
//                 requests. The next aligned redirect clears the exception
//                 and resumes fetch.
//   not defined - fetch_exc_o is tied 0 and target[1:0] is forced to 2'b00.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   stall_i             decode cannot accept; IF/ID outputs hold
//   branch_flag_i       redirect this cycle (overrides stall_i)
//   branch_target_i     redirect address
//   imem_req_o          fetch request valid
//   imem_addr_o         fetch address (current fetch pc)
//   imem_gnt_i          request accepted this cycle
//   imem_rvalid_i       response valid (in request order, >=1 cycle after gnt)
//   imem_rdata_i        response instruction word
//   pc_o, inst_o        IF/ID register: pc and instruction to decode
//   inst_valid_o        inst_o is a real instruction
//   fetch_exc_o         misaligned-target exception
//
// Parameters
//   RESET_PC            first fetch address after reset
//   FIFO_DEPTH          response buffer entries (power of 2, >=2); also the
//                       number of requests that may be in flight or buffered
module if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  output logic        fetch_exc_o
);

  localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  // fetch / response bookkeeping
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_kill;

  // response FIFO
  logic [31:0]   r_fifo_pc   [FIFO_DEPTH];
  logic [31:0]   r_fifo_inst [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  // IF/ID register
  logic [31:0]   r_pc;
  logic [31:0]   r_inst;
  logic          r_valid;

  logic [31:0]   w_target;
  logic          w_halted;
  logic          w_room;
  logic          w_req;
  logic          w_gnt;
  logic          w_resp;
  logic          w_kill_resp;
  logic          w_fifo_nonempty;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_out_next;

`ifdef FETCH_MISALIGN_CHK_EN
  logic          r_exc;
  logic          w_misalign;

  assign w_target   = branch_target_i;
  assign w_misalign = |branch_target_i[1:0];
  assign w_halted   = r_exc;
  assign fetch_exc_o = r_exc;

  // Sticky until the next redirect; an aligned redirect clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_exc <= 1'b0;
    else if (branch_flag_i) r_exc <= w_misalign;
  end
`else
  assign w_target    = branch_target_i & 32'hFFFF_FFFC;
  assign w_halted    = 1'b0;
  assign fetch_exc_o = 1'b0;
`endif

  // Credit rule: each in-flight request owns a FIFO slot. A response can
  // therefore always be buffered, even if decode stalls from now on.
  assign w_room      = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_C;
  assign w_req       = w_room && !branch_flag_i && !w_halted;
  assign w_gnt       = w_req && imem_gnt_i;

  // The first r_kill responses after a redirect belong to the old path.
  assign w_kill_resp = imem_rvalid_i && (r_kill != '0);
  assign w_resp      = imem_rvalid_i && (r_kill == '0);

  assign w_out_next  = r_outstanding + CW'(w_gnt) - CW'(imem_rvalid_i);

  assign w_fifo_nonempty = (r_count != '0);
  // A surviving response is buffered when decode stalls, or when older
  // words are already queued ahead of it. Otherwise it bypasses the FIFO.
  assign w_push = !branch_flag_i && w_resp && (stall_i || w_fifo_nonempty);
  assign w_pop  = !branch_flag_i && !stall_i && w_fifo_nonempty;

  assign imem_req_o   = w_req;
  assign imem_addr_o  = r_fetch_pc;
  assign pc_o         = r_pc;
  assign inst_o       = r_inst;
  assign inst_valid_o = r_valid;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_pc[r_wptr]   <= r_resp_pc;
      r_fifo_inst[r_wptr] <= imem_rdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_kill        <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_pc          <= RESET_PC;
      r_inst        <= NOP;
      r_valid       <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      if (branch_flag_i) begin
        // Every request still in flight after this edge is on the wrong path.
        r_kill     <= w_out_next;
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_valid    <= 1'b0;
        r_inst     <= NOP;
`ifdef FETCH_MISALIGN_CHK_EN
        if (w_misalign) r_pc <= w_target;
`endif
      end else begin
        if (w_kill_resp) r_kill     <= r_kill - CW'(1);
        if (w_gnt)       r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_resp)      r_resp_pc  <= r_resp_pc + 32'd4;
        if (w_push)      r_wptr     <= r_wptr + PW'(1);
        if (w_pop)       r_rptr     <= r_rptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);

        if (stall_i) begin
          // hold IF/ID
        end else if (w_fifo_nonempty) begin
          r_pc    <= r_fifo_pc[r_rptr];
          r_inst  <= r_fifo_inst[r_rptr];
          r_valid <= 1'b1;
        end else if (w_resp) begin
          r_pc    <= r_resp_pc;
          r_inst  <= imem_rdata_i;
          r_valid <= 1'b1;
        end else begin
          r_inst  <= NOP;
          r_valid <= 1'b0;
        end
      end
    end
  end

endmodule
